// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC generator.
// Default address map constants (32-bit; zero-extended when W > 32) and the
// next-PC source enumeration used by the target mux and debug trace.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_SIZE  = 32'h0000_4000;

  // Next-PC source, listed highest priority first.
  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_SEQ
  } npc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC calculation.
// Builds the sequential, branch, jump and register targets and picks one with
// a fixed priority: exception > eret > stall hold > branch > j > jr > pc+4.
// Ports:
//   pc_f, pc_d, epc, reg_value : W-bit PCs / target register value
//   imm16, imm26               : branch offset, jump index
//   exc_req, eret, stall,
//   branch_jump, imm_jump,
//   reg_jump                   : redirect requests
//   npc                        : selected next PC
module pc_target_calc import pc_pkg::*; #(
  parameter int             W          = 32,
  parameter logic [W-1:0]   EXC_VECTOR = W'(DEF_EXC_VECTOR)
) (
  input  logic [W-1:0] pc_f,
  input  logic [W-1:0] pc_d,
  input  logic [W-1:0] epc,
  input  logic [W-1:0] reg_value,
  input  logic [15:0]  imm16,
  input  logic [25:0]  imm26,
  input  logic         exc_req,
  input  logic         eret,
  input  logic         stall,
  input  logic         branch_jump,
  input  logic         imm_jump,
  input  logic         reg_jump,
  output logic [W-1:0] npc
);

  logic [W-1:0] apc, bpc, ipc, pc_d4;
  npc_sel_e     sel;

  // All adds wrap modulo 2^W.
  assign apc   = pc_f + W'(4);
  assign pc_d4 = pc_d + W'(4);
  assign bpc   = pc_d4 + {{(W-18){imm16[15]}}, imm16, 2'b00};
  assign ipc   = {pc_d4[W-1:28], imm26, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if      (exc_req)     sel = SEL_EXC;
    else if (eret)        sel = SEL_ERET;
    else if (stall)       sel = SEL_HOLD;
    else if (branch_jump) sel = SEL_BR;
    else if (imm_jump)    sel = SEL_J;
    else if (reg_jump)    sel = SEL_JR;
  end

  // Unselected targets never reach npc, so X on e.g. reg_value is harmless.
  always_comb begin
    npc = apc;
    case (sel)
      SEL_EXC:  npc = EXC_VECTOR;
      SEL_ERET: npc = epc;
      SEL_HOLD: npc = pc_f;
      SEL_BR:   npc = bpc;
      SEL_J:    npc = ipc;
      SEL_JR:   npc = reg_value;
      default:  npc = apc;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Holds the F-stage PC and the EPC register; next PC comes from
// pc_target_calc. Fetch fault flags are decoded combinationally from pc_f and
// are only reported: the exception unit answers them with exc_req.
// Ports:
//   clk, reset (async, active low)
//   stall, pc_d, branch_jump, imm_jump, reg_jump, imm16, imm26, reg_value
//   exc_req, exc_pc, exc_bd, eret, epc_we, epc_wdata
//   pc_f (registered), npc (combinational), epc
//   fetch_misaligned, fetch_out_of_range
module pc_gen import pc_pkg::*; #(
  parameter int           W          = 32,
  parameter logic [W-1:0] RESET_PC   = W'(DEF_RESET_PC),
  parameter logic [W-1:0] EXC_VECTOR = W'(DEF_EXC_VECTOR),
  parameter logic [W-1:0] IMEM_BASE  = W'(DEF_IMEM_BASE),
  parameter logic [W-1:0] IMEM_SIZE  = W'(DEF_IMEM_SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [W-1:0] pc_d,
  input  logic         branch_jump,
  input  logic         imm_jump,
  input  logic         reg_jump,
  input  logic [15:0]  imm16,
  input  logic [25:0]  imm26,
  input  logic [W-1:0] reg_value,
  input  logic         exc_req,
  input  logic [W-1:0] exc_pc,
  input  logic         exc_bd,
  input  logic         eret,
  input  logic         epc_we,
  input  logic [W-1:0] epc_wdata,
  output logic [W-1:0] pc_f,
  output logic [W-1:0] npc,
  output logic [W-1:0] epc,
  output logic         fetch_misaligned,
  output logic         fetch_out_of_range
);

  // Window bounds carried one bit wider so BASE+SIZE cannot wrap.
  localparam logic [W:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [W:0] WIN_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  pc_target_calc #(.W(W), .EXC_VECTOR(EXC_VECTOR)) u_calc (
    .pc_f        (pc_f),
    .pc_d        (pc_d),
    .epc         (epc),
    .reg_value   (reg_value),
    .imm16       (imm16),
    .imm26       (imm26),
    .exc_req     (exc_req),
    .eret        (eret),
    .stall       (stall),
    .branch_jump (branch_jump),
    .imm_jump    (imm_jump),
    .reg_jump    (reg_jump),
    .npc         (npc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_f <= RESET_PC;
    else        pc_f <= npc;
  end

  // eret reads the old epc through npc; a same-cycle mtc0 lands afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      epc <= '0;
    else if (exc_req) epc <= exc_bd ? exc_pc - W'(4) : exc_pc;
    else if (epc_we)  epc <= epc_wdata;
  end

  assign fetch_misaligned   = |pc_f[1:0];
  assign fetch_out_of_range = ({1'b0, pc_f} < WIN_LO) || ({1'b0, pc_f} >= WIN_HI);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_jump, imm_jump, reg_jump;
  logic        exc_req, exc_bd, eret, epc_we;
  logic [31:0] pc_d, reg_value, exc_pc, epc_wdata;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] pc_f, npc, epc;
  logic        fetch_misaligned, fetch_out_of_range;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .pc_d               (pc_d),
    .branch_jump        (branch_jump),
    .imm_jump           (imm_jump),
    .reg_jump           (reg_jump),
    .imm16              (imm16),
    .imm26              (imm26),
    .reg_value          (reg_value),
    .exc_req            (exc_req),
    .exc_pc             (exc_pc),
    .exc_bd             (exc_bd),
    .eret               (eret),
    .epc_we             (epc_we),
    .epc_wdata          (epc_wdata),
    .pc_f               (pc_f),
    .npc                (npc),
    .epc                (epc),
    .fetch_misaligned   (fetch_misaligned),
    .fetch_out_of_range (fetch_out_of_range)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; branch_jump = 0; imm_jump = 0; reg_jump = 0;
    exc_req = 0; exc_bd = 0; eret = 0; epc_we = 0;
    pc_d = '0; reg_value = '0; exc_pc = '0; epc_wdata = '0;
    imm16 = '0; imm26 = '0;
  endtask

  // One rising edge, then settle 1ns past it before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    clr();
    reg_jump = 1; reg_value = tgt;
    step();
    clr();
  endtask

  initial begin
    clr();
    reset = 0;
    #12;
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_mis", {31'b0, fetch_misaligned}, 32'd0);
    chk("rst_oor", {31'b0, fetch_out_of_range}, 32'd0);
    reset = 1;

    // 1: load epc, walk to 0x3010, async reset mid-cycle
    epc_we = 1; epc_wdata = 32'h3ABC;
    step();
    clr();
    chk("t1_first", pc_f, 32'h3004);
    chk("t1_epcw", epc, 32'h3ABC);
    step(); step(); step();
    chk("t1_3010", pc_f, 32'h3010);
    reset = 0;
    #1;
    chk("t1_async_pc", pc_f, 32'h3000);
    chk("t1_async_epc", epc, 32'h0);
    #1 reset = 1;
    step(); chk("t1_r1", pc_f, 32'h3004);
    step(); chk("t1_r2", pc_f, 32'h3008);
    step(); chk("t1_r3", pc_f, 32'h300C);

    // 2: stall holds against a held branch
    repeat (5) step();
    chk("t2_3020", pc_f, 32'h3020);
    stall = 1; branch_jump = 1; pc_d = 32'h301C; imm16 = 16'hFFFE;
    #1 chk("t2_npc_hold", npc, 32'h3020);
    step(); chk("t2_hold1", pc_f, 32'h3020);
    step(); chk("t2_hold2", pc_f, 32'h3020);
    stall = 0;
    step(); chk("t2_br", pc_f, 32'h3018);
    clr();

    // 3: j, jr, and branch priority over both
    pc_d = 32'h3040; imm_jump = 1; imm26 = 26'h0000C10;
    step(); chk("t3_j", pc_f, 32'h3040);
    clr();
    reg_jump = 1; reg_value = 32'h3100;
    step(); chk("t3_jr", pc_f, 32'h3100);
    clr();
    pc_d = 32'h3040; imm16 = 16'h0010; imm26 = 26'h0000C10; reg_value = 32'h3100;
    branch_jump = 1; imm_jump = 1; reg_jump = 1;
    step(); chk("t3_prio", pc_f, 32'h3084);
    clr();

    // 4: exception in delay slot overrides stall, then eret
    exc_req = 1; exc_pc = 32'h3050; exc_bd = 1; stall = 1;
    step();
    chk("t4_vec", pc_f, 32'h4180);
    chk("t4_epc", epc, 32'h304C);
    clr();
    eret = 1;
    step();
    chk("t4_eret", pc_f, 32'h304C);
    chk("t4_epc_keep", epc, 32'h304C);
    clr();

    // 5: exc beats eret; eret with mtc0 uses old epc
    exc_req = 1; eret = 1; exc_pc = 32'h3060; exc_bd = 0;
    step();
    chk("t5_vec", pc_f, 32'h4180);
    chk("t5_epc", epc, 32'h3060);
    clr();
    eret = 1; epc_we = 1; epc_wdata = 32'h3200;
    step();
    chk("t5_eret_old", pc_f, 32'h3060);
    chk("t5_epc_new", epc, 32'h3200);
    clr();

    // 6: fault flags, window edges and APC wrap
    jr_to(32'h3002);
    chk("t6_mis_pc", pc_f, 32'h3002);
    chk("t6_mis", {31'b0, fetch_misaligned}, 32'd1);
    chk("t6_mis_oor", {31'b0, fetch_out_of_range}, 32'd0);
    jr_to(32'h6FFC);
    chk("t6_top_oor", {31'b0, fetch_out_of_range}, 32'd0);
    chk("t6_top_mis", {31'b0, fetch_misaligned}, 32'd0);
    jr_to(32'h7000);
    chk("t6_end_oor", {31'b0, fetch_out_of_range}, 32'd1);
    jr_to(32'h2FFC);
    chk("t6_low_oor", {31'b0, fetch_out_of_range}, 32'd1);
    jr_to(32'hFFFF_FFFC);
    chk("t6_hi_pc", pc_f, 32'hFFFF_FFFC);
    chk("t6_hi_oor", {31'b0, fetch_out_of_range}, 32'd1);
    #1 chk("t6_npc_wrap", npc, 32'h0);
    step();
    chk("t6_wrap", pc_f, 32'h0);
    chk("t6_wrap_oor", {31'b0, fetch_out_of_range}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
